// File: rtl/char_rom_arbiter.sv
// char_rom_arbiter: shares one synchronous character-sprite ROM read port between the
// host and guest char draw units. Round-robin with a bounded burst length, a registered
// ROM request stage and an owner-tagged return pipeline so each unit sees only its data.
module char_rom_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 12,
  parameter int ROM_LAT   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_host,
  input  logic [ADDR_W-1:0] addr_host,
  input  logic              req_guest,
  input  logic [ADDR_W-1:0] addr_guest,
  output logic              gnt_host,
  output logic              gnt_guest,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              rvalid_host,
  output logic              rvalid_guest,
  output logic [DATA_W-1:0] rdata_host,
  output logic [DATA_W-1:0] rdata_guest
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOST,
    GUEST
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_guest;
  logic             burst_done;
  logic             gnt_any;
  logic [CNT_W-1:0] burst_inc;

  // Entry 0 is loaded on the grant edge; entry ROM_LAT lines up with rom_rdata.
  logic [ROM_LAT:0] tag_valid;
  logic [ROM_LAT:0] tag_guest;

  assign burst_done = (burst_cnt == BURST_LAST);
  assign burst_inc  = burst_done ? burst_cnt : burst_cnt + CNT_W'(1);
  assign gnt_any    = gnt_host | gnt_guest;

  // Grant decision: the owner keeps the port until its burst runs out while the other side waits.
  always_comb begin
    gnt_host  = 1'b0;
    gnt_guest = 1'b0;
    case (state)
      HOST: begin
        if (req_host && !(req_guest && burst_done)) gnt_host = 1'b1;
        else if (req_guest)                         gnt_guest = 1'b1;
      end
      GUEST: begin
        if (req_guest && !(req_host && burst_done)) gnt_guest = 1'b1;
        else if (req_host)                          gnt_host = 1'b1;
      end
      default: begin
        if (req_host && req_guest) begin
          if (last_guest) gnt_host = 1'b1;
          else            gnt_guest = 1'b1;
        end else if (req_host) begin
          gnt_host = 1'b1;
        end else if (req_guest) begin
          gnt_guest = 1'b1;
        end
      end
    endcase
  end

  // Owner FSM: tracks who holds the port, how long they have held it, and who went last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_guest <= 1'b1;
    end else if (gnt_host) begin
      state      <= HOST;
      burst_cnt  <= (state == HOST) ? burst_inc : '0;
      last_guest <= 1'b0;
    end else if (gnt_guest) begin
      state      <= GUEST;
      burst_cnt  <= (state == GUEST) ? burst_inc : '0;
      last_guest <= 1'b1;
    end else begin
      state      <= IDLE;
      burst_cnt  <= '0;
    end
  end

  // ROM request stage: the accepted address is presented to the ROM the cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= gnt_any;
      if (gnt_any) rom_addr <= gnt_host ? addr_host : addr_guest;
    end
  end

  // Return tags ride alongside the ROM latency; clearing them on reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_guest <= '0;
    end else begin
      tag_valid <= {tag_valid[ROM_LAT-1:0], gnt_any};
      tag_guest <= {tag_guest[ROM_LAT-1:0], gnt_guest};
    end
  end

  assign rvalid_host  = tag_valid[ROM_LAT] & ~tag_guest[ROM_LAT];
  assign rvalid_guest = tag_valid[ROM_LAT] &  tag_guest[ROM_LAT];
  assign rdata_host   = rom_rdata;
  assign rdata_guest  = rom_rdata;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// tb_char_rom_arbiter: directed table vectors plus hand-written corner sequences and a
// randomised scoreboard run for the character ROM arbiter (ROM data = addr[11:0], latency 2).
module tb_char_rom_arbiter;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 12;
  localparam int ROM_LAT   = 2;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_host = 1'b0;
  logic [ADDR_W-1:0] addr_host = '0;
  logic              req_guest = 1'b0;
  logic [ADDR_W-1:0] addr_guest = '0;
  logic              gnt_host, gnt_guest, rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata, rdata_host, rdata_guest;
  logic              rvalid_host, rvalid_guest;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic              rh;
    logic [ADDR_W-1:0] ah;
    logic              rg;
    logic [ADDR_W-1:0] ag;
    logic              egh;
    logic              egg;
    logic              een;
    logic [ADDR_W-1:0] eaddr;
    logic              evh;
    logic              evg;
    logic [DATA_W-1:0] ed;
  } vec_t;

  typedef struct {
    logic              guest;
    logic [DATA_W-1:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  char_rom_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req_host(req_host), .addr_host(addr_host),
    .req_guest(req_guest), .addr_guest(addr_guest),
    .gnt_host(gnt_host), .gnt_guest(gnt_guest),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .rvalid_host(rvalid_host), .rvalid_guest(rvalid_guest),
    .rdata_host(rdata_host), .rdata_guest(rdata_guest)
  );

  always #5 clk = ~clk;

  // Two-stage synchronous ROM whose word content is the low 12 address bits.
  logic [DATA_W-1:0] rom_p1, rom_p2;
  always @(posedge clk) begin
    rom_p1 <= rom_addr[11:0];
    rom_p2 <= rom_p1;
  end
  assign rom_rdata = rom_p2;

  function automatic vec_t mk(logic rh, logic [ADDR_W-1:0] ah, logic rg, logic [ADDR_W-1:0] ag,
                              logic egh, logic egg, logic een, logic [ADDR_W-1:0] eaddr,
                              logic evh, logic evg, logic [DATA_W-1:0] ed);
    vec_t v;
    v.rh = rh; v.ah = ah; v.rg = rg; v.ag = ag;
    v.egh = egh; v.egg = egg; v.een = een; v.eaddr = eaddr;
    v.evh = evh; v.evg = evg; v.ed = ed;
    return v;
  endfunction

  task automatic cmp(input string what, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, want);
    end
  endtask

  task automatic flag(input string what, input logic bad);
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("[TB] FAIL %s: gh=%0b gg=%0b rh=%0b rg=%0b vh=%0b vg=%0b", what,
               gnt_host, gnt_guest, req_host, req_guest, rvalid_host, rvalid_guest);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rh, input logic [ADDR_W-1:0] ah,
                               input logic rg, input logic [ADDR_W-1:0] ag);
    rst        = r;
    req_host   = rh;
    addr_host  = ah;
    req_guest  = rg;
    addr_guest = ag;
  endtask

  task automatic checkOutput(input string tag, input logic egh, input logic egg, input logic een,
                             input logic [ADDR_W-1:0] eaddr, input logic evh, input logic evg,
                             input logic [DATA_W-1:0] ed);
    cmp({tag, " gnt_host"}, 32'(gnt_host), 32'(egh));
    cmp({tag, " gnt_guest"}, 32'(gnt_guest), 32'(egg));
    cmp({tag, " rom_en"}, 32'(rom_en), 32'(een));
    cmp({tag, " rom_addr"}, 32'(rom_addr), 32'(eaddr));
    cmp({tag, " rvalid_host"}, 32'(rvalid_host), 32'(evh));
    cmp({tag, " rvalid_guest"}, 32'(rvalid_guest), 32'(evg));
    if (evh) cmp({tag, " rdata_host"}, 32'(rdata_host), 32'(ed));
    if (evg) cmp({tag, " rdata_guest"}, 32'(rdata_guest), 32'(ed));
  endtask

  // One bench cycle: inputs just after the rising edge, checks on the falling edge.
  task automatic doCycle(input string tag, input logic r, input logic rh, input logic [ADDR_W-1:0] ah,
                         input logic rg, input logic [ADDR_W-1:0] ag,
                         input logic egh, input logic egg, input logic een,
                         input logic [ADDR_W-1:0] eaddr, input logic evh, input logic evg,
                         input logic [DATA_W-1:0] ed);
    applyStimulus(r, rh, ah, rg, ag);
    @(negedge clk);
    checkOutput(tag, egh, egg, een, eaddr, evh, evg, ed);
    @(posedge clk);
    #1;
  endtask

  // Random-run return checking: each rvalid must match the oldest outstanding grant.
  task automatic scoreReturn(input string tag);
    sb_t e;
    if (rvalid_host || rvalid_guest) begin
      if (rvalid_host && rvalid_guest) begin
        flag({tag, " both_rvalid"}, 1'b1);
      end else if (sb.size() == 0) begin
        flag({tag, " rvalid_without_grant"}, 1'b1);
      end else begin
        e = sb.pop_front();
        cmp({tag, " return_owner_guest"}, 32'(rvalid_guest), 32'(e.guest));
        cmp({tag, " return_data"}, 32'(rvalid_guest ? rdata_guest : rdata_host), 32'(e.data));
      end
    end
  endtask

  initial begin
    sb_t e;
    logic host_took, guest_took;
    int wait_h, wait_g;

    // Contention from the first cycle after reset: host 4, guest 4, host 4
    vecs.push_back(mk(0, 'h00, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 'h00));
    vecs.push_back(mk(1, 'h10, 1, 'h20, 1, 0, 0, 'h00, 0, 0, 'h00));
    vecs.push_back(mk(1, 'h11, 1, 'h20, 1, 0, 1, 'h10, 0, 0, 'h00));
    vecs.push_back(mk(1, 'h12, 1, 'h20, 1, 0, 1, 'h11, 0, 0, 'h00));
    vecs.push_back(mk(1, 'h13, 1, 'h20, 1, 0, 1, 'h12, 1, 0, 'h10));
    vecs.push_back(mk(1, 'h14, 1, 'h20, 0, 1, 1, 'h13, 1, 0, 'h11));
    vecs.push_back(mk(1, 'h14, 1, 'h21, 0, 1, 1, 'h20, 1, 0, 'h12));
    vecs.push_back(mk(1, 'h14, 1, 'h22, 0, 1, 1, 'h21, 1, 0, 'h13));
    vecs.push_back(mk(1, 'h14, 1, 'h23, 0, 1, 1, 'h22, 0, 1, 'h20));
    vecs.push_back(mk(1, 'h14, 1, 'h24, 1, 0, 1, 'h23, 0, 1, 'h21));
    vecs.push_back(mk(1, 'h15, 1, 'h24, 1, 0, 1, 'h14, 0, 1, 'h22));
    vecs.push_back(mk(1, 'h16, 1, 'h24, 1, 0, 1, 'h15, 0, 1, 'h23));
    vecs.push_back(mk(1, 'h17, 1, 'h24, 1, 0, 1, 'h16, 1, 0, 'h14));
    vecs.push_back(mk(0, 'h00, 0, 'h00, 0, 0, 1, 'h17, 1, 0, 'h15));
    vecs.push_back(mk(0, 'h00, 0, 'h00, 0, 0, 0, 'h17, 1, 0, 'h16));
    vecs.push_back(mk(0, 'h00, 0, 'h00, 0, 0, 0, 'h17, 1, 0, 'h17));
    vecs.push_back(mk(0, 'h00, 0, 'h00, 0, 0, 0, 'h17, 0, 0, 'h00));
    // Host bursts twice then drops; guest takes over and keeps 4 grants before host returns
    vecs.push_back(mk(1, 'h30, 0, 'h00, 1, 0, 0, 'h17, 0, 0, 'h00));
    vecs.push_back(mk(1, 'h31, 1, 'h40, 1, 0, 1, 'h30, 0, 0, 'h00));
    vecs.push_back(mk(0, 'h00, 1, 'h40, 0, 1, 1, 'h31, 0, 0, 'h00));
    vecs.push_back(mk(1, 'h32, 1, 'h41, 0, 1, 1, 'h40, 1, 0, 'h30));
    vecs.push_back(mk(1, 'h32, 1, 'h42, 0, 1, 1, 'h41, 1, 0, 'h31));
    vecs.push_back(mk(1, 'h32, 1, 'h43, 0, 1, 1, 'h42, 0, 1, 'h40));
    vecs.push_back(mk(1, 'h32, 1, 'h44, 1, 0, 1, 'h43, 0, 1, 'h41));
    vecs.push_back(mk(0, 'h00, 0, 'h00, 0, 0, 1, 'h32, 0, 1, 'h42));
    vecs.push_back(mk(0, 'h00, 0, 'h00, 0, 0, 0, 'h32, 0, 1, 'h43));
    vecs.push_back(mk(0, 'h00, 0, 'h00, 0, 0, 0, 'h32, 1, 0, 'h32));
    vecs.push_back(mk(0, 'h00, 0, 'h00, 0, 0, 0, 'h32, 0, 0, 'h00));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      doCycle($sformatf("table[%0d]", i), 1'b0, vecs[i].rh, vecs[i].ah, vecs[i].rg, vecs[i].ag,
              vecs[i].egh, vecs[i].egg, vecs[i].een, vecs[i].eaddr,
              vecs[i].evh, vecs[i].evg, vecs[i].ed);
    end

    // Host alone, addresses 0..9 back to back; data returns three cycles after each grant
    for (int c = 0; c < 14; c++) begin
      doCycle($sformatf("host_stream[%0d]", c), 1'b0, c < 10, ADDR_W'(c), 1'b0, '0,
              c < 10, 1'b0, (c >= 1 && c <= 10),
              (c == 0) ? ADDR_W'('h32) : ((c <= 10) ? ADDR_W'(c - 1) : ADDR_W'(9)),
              (c >= 3 && c <= 12), 1'b0, DATA_W'(c - 3));
    end

    // Single guest pulse while host is idle
    for (int c = 0; c < 10; c++) begin
      doCycle($sformatf("guest_pulse[%0d]", c), 1'b0, 1'b0, '0, c == 5,
              (c == 5) ? ADDR_W'('h123) : ADDR_W'(0),
              1'b0, c == 5, c == 6, (c <= 5) ? ADDR_W'(9) : ADDR_W'('h123),
              1'b0, c == 8, DATA_W'('h123));
    end

    // Reset the cycle after a host grant: the read is dropped and round-robin restarts with host
    doCycle("rst_mid[0]", 1'b0, 1'b1, 'h55, 1'b0, 'h00, 1, 0, 0, 'h123, 0, 0, 'h00);
    doCycle("rst_mid[1]", 1'b1, 1'b0, 'h00, 1'b0, 'h00, 0, 0, 1, 'h55, 0, 0, 'h00);
    doCycle("rst_mid[2]", 1'b0, 1'b0, 'h00, 1'b0, 'h00, 0, 0, 0, 'h00, 0, 0, 'h00);
    doCycle("rst_mid[3]", 1'b0, 1'b0, 'h00, 1'b0, 'h00, 0, 0, 0, 'h00, 0, 0, 'h00);
    doCycle("rst_mid[4]", 1'b0, 1'b1, 'h66, 1'b1, 'h77, 1, 0, 0, 'h00, 0, 0, 'h00);
    doCycle("rst_mid[5]", 1'b0, 1'b0, 'h00, 1'b0, 'h00, 0, 0, 1, 'h66, 0, 0, 'h00);
    doCycle("rst_mid[6]", 1'b0, 1'b0, 'h00, 1'b0, 'h00, 0, 0, 0, 'h66, 0, 0, 'h00);
    doCycle("rst_mid[7]", 1'b0, 1'b0, 'h00, 1'b0, 'h00, 0, 0, 0, 'h66, 1, 0, 'h66);
    doCycle("rst_mid[8]", 1'b0, 1'b0, 'h00, 1'b0, 'h00, 0, 0, 0, 'h66, 0, 0, 'h00);

    // Random traffic: requesters hold req/addr until granted, scoreboard checks every return
    host_took  = 1'b0;
    guest_took = 1'b0;
    wait_h     = 0;
    wait_g     = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!req_host || host_took) begin
        req_host  = ($urandom_range(99) < 70);
        addr_host = ADDR_W'($urandom);
      end
      if (!req_guest || guest_took) begin
        req_guest  = ($urandom_range(99) < 70);
        addr_guest = ADDR_W'($urandom);
      end
      @(negedge clk);
      flag("rand gnt_without_req", (gnt_host && !req_host) || (gnt_guest && !req_guest));
      flag("rand both_gnt", gnt_host && gnt_guest);
      scoreReturn("rand");
      wait_h = (req_host && !gnt_host) ? wait_h + 1 : 0;
      wait_g = (req_guest && !gnt_guest) ? wait_g + 1 : 0;
      flag("rand starvation", (wait_h > MAX_BURST) || (wait_g > MAX_BURST));
      if (gnt_host) begin
        e.guest = 1'b0;
        e.data  = addr_host[11:0];
        sb.push_back(e);
      end else if (gnt_guest) begin
        e.guest = 1'b1;
        e.data  = addr_guest[11:0];
        sb.push_back(e);
      end
      host_took  = gnt_host;
      guest_took = gnt_guest;
      @(posedge clk);
      #1;
    end

    // Drain outstanding reads with no new requests
    req_host  = 1'b0;
    req_guest = 1'b0;
    for (int c = 0; c < ROM_LAT + 3; c++) begin
      @(negedge clk);
      scoreReturn("drain");
      @(posedge clk);
      #1;
    end
    cmp("drain outstanding_reads", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
